// File: rtl/cp0_reg_pkg.sv
// ============================================================================
// Module      : cp0_reg_pkg
// Description : CP0 register addresses, exception codes, cp0_bus layout and
//               field masks shared by the CP0 block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_reg_pkg;

    // cp0_bus layout: [37] we, [36:32] waddr, [31:0] wdata
    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } cp0_wr_t;

    localparam int          c_bus_w         = 38;

    localparam logic [4:0]  c_addr_badvaddr = 5'd8;
    localparam logic [4:0]  c_addr_count    = 5'd9;
    localparam logic [4:0]  c_addr_compare  = 5'd11;
    localparam logic [4:0]  c_addr_status   = 5'd12;
    localparam logic [4:0]  c_addr_cause    = 5'd13;
    localparam logic [4:0]  c_addr_epc      = 5'd14;

    localparam logic [31:0] c_exc_int       = 32'h0000_0001;
    localparam logic [31:0] c_exc_adel      = 32'h0000_0004;
    localparam logic [31:0] c_exc_ades      = 32'h0000_0005;
    localparam logic [31:0] c_exc_sys       = 32'h0000_0008;
    localparam logic [31:0] c_exc_bp        = 32'h0000_0009;
    localparam logic [31:0] c_exc_ri        = 32'h0000_000A;
    localparam logic [31:0] c_exc_ov        = 32'h0000_000C;
    localparam logic [31:0] c_exc_eret      = 32'h0000_000E;

    localparam logic [31:0] c_status_reset  = 32'h0040_0000;
    localparam logic [31:0] c_status_wmask  = 32'h0000_FF03;

    function automatic logic exc_known(input logic [31:0] code);
        case (code)
            c_exc_int, c_exc_adel, c_exc_ades, c_exc_sys,
            c_exc_bp, c_exc_ri, c_exc_ov, c_exc_eret: exc_known = 1'b1;
            default:                                   exc_known = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_reg_if.sv
// ============================================================================
// Module      : cp0_reg_if
// Description : Write-back / read / redirect signal bundle between the
//               pipeline (master) and CP0 (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_reg_if;
    import cp0_reg_pkg::*;

    logic [c_bus_w-1:0] cp0_bus;
    logic [31:0]        excepttype_i;
    logic [31:0]        exc_pc_i;
    logic               is_in_delayslot_i;
    logic [31:0]        bad_vaddr_i;
    logic [5:0]         int_i;
    logic [4:0]         raddr;
    logic [31:0]        rdata;
    logic               flush;
    logic [31:0]        new_pc;
    logic [31:0]        epc_o;
    logic [31:0]        status_o;
    logic [31:0]        cause_o;
    logic               timer_int_o;

    modport master (
        output cp0_bus, excepttype_i, exc_pc_i, is_in_delayslot_i,
               bad_vaddr_i, int_i, raddr,
        input  rdata, flush, new_pc, epc_o, status_o, cause_o, timer_int_o
    );

    modport slave (
        input  cp0_bus, excepttype_i, exc_pc_i, is_in_delayslot_i,
               bad_vaddr_i, int_i, raddr,
        output rdata, flush, new_pc, epc_o, status_o, cause_o, timer_int_o
    );

endinterface

`default_nettype wire

// File: rtl/cp0_reg_timer.sv
// ============================================================================
// Module      : cp0_reg_timer
// Description : Count/Compare pair with half-rate tick and sticky timer
//               interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_reg_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
        end else begin
            r_tick <= ~r_tick;
            if (we_count)
                r_count <= wdata;
            else if (r_tick)
                r_count <= r_count + 32'd1;
            if (we_compare)
                r_compare <= wdata;
        end
    end

    // Writing Compare acknowledges the interrupt, even on a matching cycle
    always_ff @(posedge clk) begin
        if (rst)
            r_timer_int <= 1'b0;
        else if (we_compare)
            r_timer_int <= 1'b0;
        else if ((r_compare != 32'd0) && (r_count == r_compare))
            r_timer_int <= 1'b1;
    end

    assign count     = r_count;
    assign compare   = r_compare;
    assign timer_int = r_timer_int;

endmodule

`default_nettype wire

// File: rtl/cp0_reg.sv
// ============================================================================
// Module      : cp0_reg
// Description : MIPS CP0 subset - status/cause/EPC/BadVAddr, exception entry
//               and eret redirect, mtc0/mfc0 access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic     clk,
    input  logic     rst,
    cp0_reg_if.slave cp0
);

    cp0_wr_t     w_wr;
    logic        w_known, w_eret, w_exc, w_addr_exc, w_exl;
    logic        w_we_count, w_we_compare, w_we_status, w_we_cause, w_we_epc;
    logic        w_timer_int;
    logic [31:0] w_count, w_compare, w_cause, w_epc_fwd, w_rdata;
    logic [31:0] w_status_nxt;

    logic [31:0] r_badvaddr;
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_ip_hw;

    assign w_wr       = cp0_wr_t'(cp0.cp0_bus);
    assign w_known    = exc_known(cp0.excepttype_i);
    assign w_eret     = (cp0.excepttype_i == c_exc_eret);
    assign w_exc      = w_known & ~w_eret;
    assign w_addr_exc = (cp0.excepttype_i == c_exc_adel) | (cp0.excepttype_i == c_exc_ades);
    assign w_exl      = r_status[1];

    assign w_we_count   = w_wr.we & (w_wr.addr == c_addr_count);
    assign w_we_compare = w_wr.we & (w_wr.addr == c_addr_compare);
    assign w_we_status  = w_wr.we & (w_wr.addr == c_addr_status);
    assign w_we_cause   = w_wr.we & (w_wr.addr == c_addr_cause);
    assign w_we_epc     = w_wr.we & (w_wr.addr == c_addr_epc);

    cp0_reg_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .we_count   (w_we_count),
        .we_compare (w_we_compare),
        .wdata      (w_wr.data),
        .count      (w_count),
        .compare    (w_compare),
        .timer_int  (w_timer_int)
    );

    // Exception/eret own EXL; mtc0 only reaches the other writable bits
    always_comb begin
        w_status_nxt = r_status;
        if (w_we_status)
            w_status_nxt = (r_status & ~c_status_wmask) | (w_wr.data & c_status_wmask);
        if (w_exc)
            w_status_nxt[1] = 1'b1;
        else if (w_eret)
            w_status_nxt[1] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr <= '0;
            r_status   <= c_status_reset;
            r_epc      <= '0;
            r_bd       <= 1'b0;
            r_exccode  <= '0;
            r_ip_sw    <= '0;
            r_ip_hw    <= '0;
        end else begin
            r_status <= w_status_nxt;
            r_ip_hw  <= cp0.int_i;
            if (w_we_cause)
                r_ip_sw <= w_wr.data[9:8];
            if (w_exc)
                r_exccode <= cp0.excepttype_i[4:0];
            if (w_exc && w_addr_exc)
                r_badvaddr <= cp0.bad_vaddr_i;
            // A nested exception keeps the original return point
            if (w_exc && !w_exl) begin
                r_epc <= cp0.is_in_delayslot_i ? (cp0.exc_pc_i - 32'd4) : cp0.exc_pc_i;
                r_bd  <= cp0.is_in_delayslot_i;
            end else if (w_we_epc) begin
                r_epc <= w_wr.data;
            end
        end
    end

    assign w_cause = {r_bd, w_timer_int, 14'b0, (r_ip_hw[5] | w_timer_int), r_ip_hw[4:0],
                      r_ip_sw, 1'b0, r_exccode, 2'b00};

    assign w_epc_fwd = w_we_epc ? w_wr.data : r_epc;

    always_comb begin
        w_rdata = '0;
        if (w_wr.we && (w_wr.addr == cp0.raddr)) begin
            w_rdata = w_wr.data;
        end else begin
            case (cp0.raddr)
                c_addr_badvaddr: w_rdata = r_badvaddr;
                c_addr_count:    w_rdata = w_count;
                c_addr_compare:  w_rdata = w_compare;
                c_addr_status:   w_rdata = r_status;
                c_addr_cause:    w_rdata = w_cause;
                c_addr_epc:      w_rdata = r_epc;
                default:         w_rdata = '0;
            endcase
        end
    end

    assign cp0.rdata       = w_rdata;
    assign cp0.flush       = ~rst & w_known;
    assign cp0.new_pc      = rst    ? 32'd0 :
                             w_eret ? w_epc_fwd :
                             w_exc  ? EXC_VECTOR : 32'd0;
    assign cp0.epc_o       = r_epc;
    assign cp0.status_o    = r_status;
    assign cp0.cause_o     = w_cause;
    assign cp0.timer_int_o = w_timer_int;

endmodule

`default_nettype wire

// File: tb/tb_cp0_reg.sv
// ============================================================================
// Module      : tb_cp0_reg
// Description : Directed and randomized bench for cp0_reg against an
//               in-bench behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_reg_if bus ();

    cp0_reg #(.EXC_VECTOR(32'hBFC0_0380)) dut (
        .clk (clk),
        .rst (rst),
        .cp0 (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus for the current cycle
    logic        d_rst, d_we, d_ds;
    logic [4:0]  d_waddr, d_raddr;
    logic [31:0] d_wdata, d_code, d_pc, d_badv;
    logic [5:0]  d_int;

    // Behavioural model; Count is base + half the edges elapsed since it was set
    logic [31:0] m_cbase, m_compare, m_status, m_epc, m_badv;
    int unsigned m_cn, m_cs, m_edges;
    logic        m_ti, m_bd;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;

    logic [31:0] valid_codes [8] = '{32'h01, 32'h04, 32'h05, 32'h08,
                                     32'h09, 32'h0A, 32'h0C, 32'h0E};
    logic [4:0]  impl_addrs [6]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit known(input logic [31:0] c);
        foreach (valid_codes[i])
            if (valid_codes[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_count();
        return m_cbase + 32'((m_cn + m_cs) / 2);
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'b0, (m_hw[5] | m_ti), m_hw[4:0], m_ipsw, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_rdata();
        if (d_we && d_waddr == d_raddr) return d_wdata;
        case (d_raddr)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_cbase = 0; m_cn = 0; m_cs = 0; m_edges = 0;
        m_compare = 0; m_status = 32'h0040_0000; m_epc = 0; m_badv = 0;
        m_ti = 0; m_bd = 0; m_exc = 0; m_ipsw = 0; m_hw = 0;
    endtask

    task automatic model_update();
        logic [31:0] old_count;
        logic        old_exl, is_exc, is_eret;
        if (d_rst) begin
            model_reset();
            return;
        end
        old_count = m_count();
        old_exl   = m_status[1];
        is_eret   = (d_code == 32'h0E);
        is_exc    = known(d_code) && !is_eret;
        m_edges++;
        if (d_we && d_waddr == 5'd11) begin
            m_compare = d_wdata;
            m_ti      = 1'b0;
        end else if (m_compare != 0 && old_count == m_compare) begin
            m_ti = 1'b1;
        end
        if (d_we && d_waddr == 5'd9) begin
            m_cbase = d_wdata; m_cn = 0; m_cs = m_edges % 2;
        end else begin
            m_cn++;
        end
        if (d_we && d_waddr == 5'd12)
            m_status = (m_status & ~32'h0000_FF03) | (d_wdata & 32'h0000_FF03);
        if (is_exc)       m_status[1] = 1'b1;
        else if (is_eret) m_status[1] = 1'b0;
        m_hw = d_int;
        if (d_we && d_waddr == 5'd13) m_ipsw = d_wdata[9:8];
        if (d_we && d_waddr == 5'd14) m_epc = d_wdata;
        if (is_exc) begin
            m_exc = d_code[4:0];
            if (!old_exl) begin
                m_bd  = d_ds;
                m_epc = d_ds ? d_pc - 32'd4 : d_pc;
            end
            if (d_code == 32'h04 || d_code == 32'h05) m_badv = d_badv;
        end
    endtask

    task automatic set_idle();
        d_rst = 0; d_we = 0; d_waddr = 0; d_wdata = 0; d_code = 0;
        d_pc = 0; d_ds = 0; d_badv = 0; d_int = 0; d_raddr = 0;
    endtask

    task automatic apply_check();
        logic        exp_flush;
        logic [31:0] exp_pc;
        rst                   = d_rst;
        bus.cp0_bus           = {d_we, d_waddr, d_wdata};
        bus.excepttype_i      = d_code;
        bus.exc_pc_i          = d_pc;
        bus.is_in_delayslot_i = d_ds;
        bus.bad_vaddr_i       = d_badv;
        bus.int_i             = d_int;
        bus.raddr             = d_raddr;
        #1;
        exp_flush = !d_rst && known(d_code);
        if (!exp_flush)             exp_pc = 32'd0;
        else if (d_code == 32'h0E)  exp_pc = (d_we && d_waddr == 5'd14) ? d_wdata : m_epc;
        else                        exp_pc = 32'hBFC0_0380;
        chk("flush",  32'(bus.flush), 32'(exp_flush));
        chk("new_pc", bus.new_pc, exp_pc);
        chk("rdata",  bus.rdata, m_rdata());
        chk("epc",    bus.epc_o, m_epc);
        chk("status", bus.status_o, m_status);
        chk("cause",  bus.cause_o, m_cause());
        chk("timer",  32'(bus.timer_int_o), 32'(m_ti));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int  waited;
        bit  seen;
        set_idle();
        d_rst = 1;
        rst   = 1;
        apply_check_inputs_only: begin
            bus.cp0_bus = '0; bus.excepttype_i = 0; bus.exc_pc_i = 0;
            bus.is_in_delayslot_i = 0; bus.bad_vaddr_i = 0; bus.int_i = 0; bus.raddr = 0;
        end
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        set_idle();

        // Ten idle edges after reset: Count advances every second clock
        repeat (10) begin set_idle(); apply_check(); clock_edge(); end
        set_idle(); d_raddr = 5'd9; apply_check();
        chk("reset_count5",  bus.rdata, 32'd5);
        chk("reset_status",  bus.status_o, 32'h0040_0000);
        chk("reset_flush",   32'(bus.flush), 32'd0);
        clock_edge();

        // Timer: Compare=8, Count=0
        set_idle(); d_we = 1; d_waddr = 5'd11; d_wdata = 32'd8; apply_check(); clock_edge();
        set_idle(); d_we = 1; d_waddr = 5'd9;  d_wdata = 32'd0; apply_check(); clock_edge();
        waited = 0; seen = 0;
        while (!seen && waited < 40) begin
            set_idle(); d_raddr = 5'd9; apply_check();
            if (bus.timer_int_o) begin
                seen = 1;
                chk("timer_rise_count", bus.rdata, 32'd8);
                chk("timer_cause30", 32'(bus.cause_o[30]), 32'd1);
            end
            clock_edge();
            waited++;
        end
        chk("timer_rise", 32'(seen), 32'd1);
        set_idle(); d_we = 1; d_waddr = 5'd11; d_wdata = 32'd100; apply_check(); clock_edge();
        set_idle(); apply_check();
        chk("timer_clear", 32'(bus.timer_int_o), 32'd0);
        clock_edge();

        // Overflow in a delay slot
        set_idle(); d_code = 32'h0C; d_pc = 32'hBFC0_0100; d_ds = 1; apply_check();
        chk("ov_flush",  32'(bus.flush), 32'd1);
        chk("ov_new_pc", bus.new_pc, 32'hBFC0_0380);
        clock_edge();
        set_idle(); apply_check();
        chk("ov_epc",     bus.epc_o, 32'hBFC0_00FC);
        chk("ov_bd",      32'(bus.cause_o[31]), 32'd1);
        chk("ov_exccode", 32'(bus.cause_o[6:2]), 32'h0C);
        chk("ov_exl",     32'(bus.status_o[1]), 32'd1);
        clock_edge();

        // AdEL while EXL already set
        set_idle(); d_code = 32'h04; d_pc = 32'h1234_5678; d_badv = 32'h8000_0001; apply_check(); clock_edge();
        set_idle(); d_raddr = 5'd8; apply_check();
        chk("adel_badv",    bus.rdata, 32'h8000_0001);
        chk("adel_epc",     bus.epc_o, 32'hBFC0_00FC);
        chk("adel_exccode", 32'(bus.cause_o[6:2]), 32'h04);
        clock_edge();

        // eret with a same-cycle EPC write
        set_idle(); d_we = 1; d_waddr = 5'd14; d_wdata = 32'hBFC0_0200; apply_check(); clock_edge();
        set_idle(); d_we = 1; d_waddr = 5'd14; d_wdata = 32'hBFC0_0300; d_code = 32'h0E; apply_check();
        chk("eret_new_pc", bus.new_pc, 32'hBFC0_0300);
        clock_edge();
        set_idle(); apply_check();
        chk("eret_exl", 32'(bus.status_o[1]), 32'd0);
        clock_edge();

        // Syscall racing an mtc0 Status that clears EXL
        set_idle(); d_we = 1; d_waddr = 5'd12; d_wdata = 32'h0000_FF01; d_code = 32'h08; d_raddr = 5'd12;
        apply_check();
        chk("status_fwd", bus.rdata, 32'h0000_FF01);
        clock_edge();
        set_idle(); apply_check();
        chk("sys_status", bus.status_o, 32'h0040_FF03);
        clock_edge();

        // Unknown code is ignored
        set_idle(); d_code = 32'h03; apply_check();
        chk("bad_code_flush", 32'(bus.flush), 32'd0);
        clock_edge();

        // Reset during an exception
        set_idle(); d_rst = 1; d_code = 32'h0C; d_pc = 32'h0000_4000; apply_check();
        chk("rst_flush",  32'(bus.flush), 32'd0);
        chk("rst_new_pc", bus.new_pc, 32'd0);
        clock_edge();
        set_idle(); apply_check();
        chk("rst_status", bus.status_o, 32'h0040_0000);
        chk("rst_epc",    bus.epc_o, 32'd0);
        clock_edge();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            d_rst   = ($urandom_range(0, 299) == 0);
            d_we    = ($urandom_range(0, 2) == 0);
            d_waddr = ($urandom_range(0, 3) != 0) ? impl_addrs[$urandom_range(0, 5)] : 5'($urandom);
            d_wdata = $urandom;
            if (d_waddr == 5'd11 && $urandom_range(0, 1) == 1) d_wdata = $urandom_range(0, 40);
            if (d_waddr == 5'd9) begin
                case ($urandom_range(0, 2))
                    0: d_wdata = $urandom_range(0, 40);
                    1: d_wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
                    default: ;
                endcase
            end
            case ($urandom_range(0, 19)) inside
                [0:11]:  d_code = 0;
                [12:17]: d_code = valid_codes[$urandom_range(0, 7)];
                18:      d_code = $urandom_range(0, 31);
                default: d_code = $urandom;
            endcase
            d_pc    = $urandom;
            d_ds    = 1'($urandom);
            d_badv  = $urandom;
            d_int   = 6'($urandom);
            d_raddr = ($urandom_range(0, 2) != 0) ? impl_addrs[$urandom_range(0, 5)] : 5'($urandom);
            apply_check();
            clock_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
